// File: rtl/topdown_counter_ctrl_pkg.sv
// Shared constants and types for the top-down stall-attribution counter block.
// Component indices, CSR map and FSM state encoding.
package topdown_pkg;

    localparam int IDX_BASE       = 0;
    localparam int IDX_ICACHE     = 1;
    localparam int IDX_BPRED      = 2;
    localparam int IDX_DCACHE     = 3;
    localparam int IDX_EXECUTE    = 4;
    localparam int IDX_DEPENDENCY = 5;
    localparam int NUM_COMP       = 6;

    localparam logic [3:0] CSR_CTRL    = 4'h0;
    localparam logic [3:0] CSR_WINDOW  = 4'h1;
    localparam logic [3:0] CSR_STATUS  = 4'h2;
    localparam logic [3:0] CSR_SHADOW0 = 4'h8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_CLR     = 2;
    localparam int CTRL_SNAP    = 3;
    localparam int STATUS_OVF   = 8;

    typedef enum logic [1:0] {
        TD_IDLE = 2'd0,
        TD_RUN  = 2'd1,
        TD_DONE = 2'd2
    } td_state_e;

    function automatic logic [3:0] shadow_addr(input int idx);
        return CSR_SHADOW0 + 4'(idx);
    endfunction

endpackage

// File: rtl/topdown_counter_ctrl_if.sv
// Single-cycle CSR access port: request in, registered response out.
// Signal names follow the block's external port names.
interface topdown_counter_ctrl_if;

    logic        csr_req_i;
    logic        csr_we_i;
    logic [3:0]  csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_rvalid_o;
    logic [31:0] csr_rdata_o;

    modport master (
        output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        input  csr_rvalid_o, csr_rdata_o
    );

    modport slave (
        input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        output csr_rvalid_o, csr_rdata_o
    );

endinterface

// File: rtl/topdown_counter_ctrl_sat_counter.sv
// One saturating live counter with its snapshot shadow and sticky overflow.
module topdown_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_incr,
    input  logic             i_clr,
    input  logic             i_snap,
    input  logic             i_ovf_clr,
    output logic [CNT_W-1:0] o_live,
    output logic [CNT_W-1:0] o_shadow,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_live;
    logic [CNT_W-1:0] r_shadow;
    logic             r_ovf;

    logic             w_inc;
    logic             w_full;
    logic [CNT_W-1:0] w_next;

    assign w_inc  = i_en & i_incr;
    assign w_full = &r_live;
    assign w_next = (w_inc && !w_full) ? r_live + CNT_W'(1) : r_live;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live   <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else if (i_clr) begin
            r_live   <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // The snapshot captures this cycle's increment too.
            if (i_snap) begin
                r_shadow <= w_next;
                r_live   <= '0;
            end else begin
                r_live   <= w_next;
            end
            r_ovf <= (r_ovf & ~i_ovf_clr) | (w_inc & w_full);
        end
    end

    assign o_live   = r_live;
    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/topdown_counter_ctrl.sv
// Window sequencer, CSR decode and counter bank for the top-down monitor.
module topdown_counter_ctrl #(
    parameter int CNT_W    = 32,
    parameter int NUM_COMP = topdown_pkg::NUM_COMP
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_COMP-1:0] incr_i,
    topdown_counter_ctrl_if.slave csr,
    output logic                window_done_o,
    output logic                running_o
);

    import topdown_pkg::*;

    td_state_e     r_state;
    td_state_e     w_state_nx;
    logic [31:0]   r_window;
    logic [31:0]   r_wcnt;
    logic [31:0]   w_wcnt_nx;
    logic          r_oneshot;
    logic          r_done;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic [31:0]   w_rdata;

    logic          w_wr;
    logic          w_rd;
    logic          w_ctrl_wr;
    logic          w_clr;
    logic          w_wen;
    logic          w_run;
    logic          w_wend;
    logic          w_snap;
    logic          w_oneshot;
    logic [31:0]   w_reload;

    logic [CNT_W-1:0]    w_live   [NUM_COMP];
    logic [CNT_W-1:0]    w_shadow [NUM_COMP];
    logic [NUM_COMP-1:0] w_ovf;
    logic [NUM_COMP-1:0] w_ovf_clr;

    assign w_wr      = csr.csr_req_i & csr.csr_we_i;
    assign w_rd      = csr.csr_req_i & ~csr.csr_we_i;
    assign w_ctrl_wr = w_wr & (csr.csr_addr_i == CSR_CTRL);
    assign w_clr     = w_ctrl_wr & csr.csr_wdata_i[CTRL_CLR];
    assign w_wen     = csr.csr_wdata_i[CTRL_EN];
    assign w_run     = (r_state == TD_RUN);
    assign w_wend    = w_run & (r_window != '0) & (r_wcnt == '0);
    assign w_snap    = w_wend | (w_ctrl_wr & csr.csr_wdata_i[CTRL_SNAP]);
    assign w_oneshot = w_ctrl_wr ? csr.csr_wdata_i[CTRL_ONESHOT] : r_oneshot;
    assign w_reload  = r_window - 32'd1;

    assign w_ovf_clr = (w_wr && csr.csr_addr_i == CSR_STATUS)
                     ? csr.csr_wdata_i[STATUS_OVF +: NUM_COMP] : '0;

    // CLR overrides everything; an EN=0 write beats the window-end outcome.
    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = w_run ? r_wcnt - 32'd1 : r_wcnt;
        if (w_clr) begin
            w_state_nx = w_wen ? TD_RUN : TD_IDLE;
            w_wcnt_nx  = w_reload;
        end else begin
            if (w_run && w_snap) begin
                w_wcnt_nx  = w_reload;
                w_state_nx = w_oneshot ? TD_DONE : TD_RUN;
            end
            if (w_ctrl_wr) begin
                if (!w_wen) begin
                    w_state_nx = TD_IDLE;
                end else if (!w_run) begin
                    w_state_nx = TD_RUN;
                    w_wcnt_nx  = w_reload;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= TD_IDLE;
            r_wcnt    <= '0;
            r_window  <= '0;
            r_oneshot <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_wcnt  <= w_wcnt_nx;
            r_done  <= w_snap & ~w_clr;
            if (w_ctrl_wr)
                r_oneshot <= csr.csr_wdata_i[CTRL_ONESHOT];
            if (w_wr && csr.csr_addr_i == CSR_WINDOW)
                r_window <= csr.csr_wdata_i;
        end
    end

    for (genvar i = 0; i < NUM_COMP; i++) begin : g_cnt
        topdown_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_clk     (clk_i),
            .i_rst_n   (rst_ni),
            .i_en      (w_run),
            .i_incr    (incr_i[i]),
            .i_clr     (w_clr),
            .i_snap    (w_snap),
            .i_ovf_clr (w_ovf_clr[i]),
            .o_live    (w_live[i]),
            .o_shadow  (w_shadow[i]),
            .o_ovf     (w_ovf[i])
        );
    end

    always_comb begin
        w_rdata = '0;
        case (csr.csr_addr_i)
            CSR_CTRL:   w_rdata = {30'd0, r_oneshot, w_run};
            CSR_WINDOW: w_rdata = r_window;
            CSR_STATUS: w_rdata = (32'(w_ovf) << STATUS_OVF) | 32'(r_state);
            default: begin
                for (int i = 0; i < NUM_COMP; i++)
                    if (csr.csr_addr_i == shadow_addr(i))
                        w_rdata = 32'(w_shadow[i]);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= csr.csr_req_i;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign csr.csr_rvalid_o = r_rvalid;
    assign csr.csr_rdata_o  = r_rdata;
    assign window_done_o    = r_done;
    assign running_o        = w_run;

endmodule

// File: tb/tb_topdown_counter_ctrl.sv
// Self-checking bench for topdown_counter_ctrl: CSR scoreboard plus window timing.
module tb_topdown_counter_ctrl;

    import topdown_pkg::*;

    localparam int CNT_W = 16;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] incr = '0;
    logic       done;
    logic       running;

    topdown_counter_ctrl_if bus ();

    topdown_counter_ctrl #(
        .CNT_W (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .incr_i        (incr),
        .csr           (bus.slave),
        .window_done_o (done),
        .running_o     (running)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    int          pulses[$];
    vec_t        tbl[$];

    function void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Response monitor: a request seen at an edge must answer right after it.
    always @(posedge clk) begin
        logic pend;
        pend = bus.csr_req_i;
        cyc++;
        #1;
        if (done)
            pulses.push_back(cyc);
        if (pend) begin
            check("rvalid", 32'(bus.csr_rvalid_o), 32'd1);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL scoreboard: response with no expected entry");
            end else begin
                check(nm_q.pop_front(), bus.csr_rdata_o, exp_q.pop_front());
            end
        end else begin
            check("rvalid_idle", 32'(bus.csr_rvalid_o), 32'd0);
        end
    end

    task automatic csr_op(input logic we, input logic [3:0] a,
                          input logic [31:0] d, input logic [31:0] exp,
                          input string nm);
        bus.csr_req_i   = 1'b1;
        bus.csr_we_i    = we;
        bus.csr_addr_i  = a;
        bus.csr_wdata_i = d;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        @(negedge clk);
        bus.csr_req_i = 1'b0;
        bus.csr_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        csr_op(1'b1, a, d, 32'd0, "wr_rdata");
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp,
                      input string nm);
        csr_op(1'b0, a, 32'd0, exp, nm);
    endtask

    task automatic idle_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run_tbl();
        foreach (tbl[i])
            csr_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, tbl[i].nm);
        tbl.delete();
    endtask

    task automatic expect_pulses(input int n, input int a, input int b);
        check("pulse_count", 32'(pulses.size()), 32'(n));
        if (pulses.size() > 0)
            check("pulse0_cyc", 32'(pulses[0]), 32'(a));
        if (n > 1 && pulses.size() > 1)
            check("pulse1_cyc", 32'(pulses[1]), 32'(b));
        pulses.delete();
    endtask

    initial begin
        int e;
        int e2;
        bus.csr_req_i   = 1'b0;
        bus.csr_we_i    = 1'b0;
        bus.csr_addr_i  = '0;
        bus.csr_wdata_i = '0;

        repeat (3) @(negedge clk);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 14; a++)
            tbl.push_back('{1'b0, 4'(a), 32'd0, 32'd0, $sformatf("rst_rd_%0h", a)});
        run_tbl();

        // Free-running window of 10 on base+icache
        incr = 6'b000011;
        wr(CSR_WINDOW, 32'd10);
        wr(CSR_CTRL, 32'h1);
        e = cyc;
        check("en_running", 32'(running), 32'd1);
        idle_until(e + 21);
        tbl.push_back('{1'b0, CSR_CTRL, 32'd0, 32'h1, "ctrl_run"});
        tbl.push_back('{1'b0, CSR_STATUS, 32'd0, 32'h1, "status_run"});
        tbl.push_back('{1'b0, 4'h8, 32'd0, 32'd10, "w10_sh0"});
        tbl.push_back('{1'b0, 4'h9, 32'd0, 32'd10, "w10_sh1"});
        tbl.push_back('{1'b0, 4'hA, 32'd0, 32'd0, "w10_sh2"});
        tbl.push_back('{1'b0, 4'hB, 32'd0, 32'd0, "w10_sh3"});
        tbl.push_back('{1'b0, 4'hC, 32'd0, 32'd0, "w10_sh4"});
        tbl.push_back('{1'b0, 4'hD, 32'd0, 32'd0, "w10_sh5"});
        run_tbl();
        expect_pulses(2, e + 10, e + 20);
        incr = '0;
        wr(CSR_CTRL, 32'h4);
        check("clr_idle", 32'(running), 32'd0);

        // One-shot window of 4 on dependency
        wr(CSR_WINDOW, 32'd4);
        incr = 6'b100000;
        pulses.delete();
        wr(CSR_CTRL, 32'h3);
        e = cyc;
        idle_until(e + 8);
        expect_pulses(1, e + 4, 0);
        rd(CSR_STATUS, 32'h2, "status_done");
        rd(CSR_CTRL, 32'h2, "ctrl_done");
        rd(4'hD, 32'd4, "oneshot_sh5");
        check("done_not_running", 32'(running), 32'd0);
        wr(CSR_CTRL, 32'h8);
        rd(4'hD, 32'd0, "done_live_zero");
        rd(CSR_STATUS, 32'h0, "status_idle");
        incr = '0;

        // Read in snapshot cycle, then CLR on the wcnt==0 cycle
        wr(CSR_CTRL, 32'h4);
        wr(CSR_WINDOW, 32'd5);
        incr = 6'b000001;
        wr(CSR_CTRL, 32'h1);
        e = cyc;
        pulses.delete();
        idle_until(e + 4);
        rd(4'h8, 32'd0, "rd_in_snap_cycle");
        rd(4'h8, 32'd5, "rd_after_snap");
        idle_until(e + 9);
        wr(CSR_CTRL, 32'h5);
        e2 = e + 10;
        rd(4'h8, 32'd0, "sh0_after_clr");
        rd(CSR_STATUS, 32'h1, "status_clr_en");
        idle_until(e2 + 7);
        rd(4'h8, 32'd5, "sh0_next_window");
        expect_pulses(2, e + 5, e2 + 5);
        incr = '0;
        wr(CSR_CTRL, 32'h4);

        // SNAP while IDLE after 5 counted cycles
        wr(CSR_WINDOW, 32'd0);
        incr = 6'b000001;
        wr(CSR_CTRL, 32'h1);
        e = cyc;
        idle_until(e + 4);
        wr(CSR_CTRL, 32'h0);
        rd(4'h8, 32'd0, "idle_sh0_before");
        wr(CSR_CTRL, 32'h8);
        rd(4'h8, 32'd5, "idle_snap_sh0");
        rd(CSR_STATUS, 32'h0, "idle_snap_state");
        check("idle_snap_running", 32'(running), 32'd0);
        incr = '0;

        // Saturation of a 16-bit counter
        wr(CSR_CTRL, 32'h4);
        incr = 6'b000100;
        wr(CSR_CTRL, 32'h1);
        repeat (65600) @(negedge clk);
        incr = '0;
        wr(CSR_CTRL, 32'h0);
        wr(CSR_CTRL, 32'h8);
        rd(4'hA, 32'h0000_FFFF, "sat_sh2");
        rd(CSR_STATUS, 32'h400, "ovf_set");
        wr(CSR_STATUS, 32'h400);
        rd(CSR_STATUS, 32'h0, "ovf_w1c");
        rd(4'hA, 32'h0000_FFFF, "sat_sh2_kept");

        // Asynchronous reset in the middle of a window
        wr(CSR_WINDOW, 32'd3);
        wr(CSR_CTRL, 32'h1);
        pulses.delete();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_running", 32'(running), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_no_pulse", 32'(pulses.size()), 32'd0);
        rd(CSR_WINDOW, 32'd0, "rst_mid_window");
        rd(CSR_STATUS, 32'd0, "rst_mid_status");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
